core_dtcm_avl: RTL

- Tightly-coupled data memory, acting as an Avalon-style bus slave. It sits directly downstream of the memory-access stage's load/store unit and serves its byte-enabled single and burst reads and writes.
- Returns read data one cycle after acceptance, at full throughput.
- Handles response backpressure without dropping data.
- Storage is an on-chip byte-lane RAM.

---
 rtl/core_define.sv | 13 +
 rtl/core_dtcm_ram.sv | 30 +++
 rtl/core_dtcm_avl.sv | 112 +++++++++++
 3 files changed

// File: rtl/core_define.sv
// Shared definitions for the core data-memory slice: bus widths and the
// tightly-coupled memory controller state encoding.
package core_define;

   localparam int DATA_W      = 32;
   localparam int BE_W        = 4;
   localparam int BURST_W_DEF = 8;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_RD_BURST = 2'd1;
   localparam logic [1:0] ST_WR_BURST = 2'd2;

endpackage

// File: rtl/core_dtcm_ram.sv
// Single-port synchronous byte-lane RAM with read enable and write-first
// read data; storage and output register carry no reset.
module core_dtcm_ram
   import core_define::*;
#(
   parameter int DEPTH_WORDS = 4096
) (
   input  logic                           clk,
   input  logic                           re,
   input  logic [BE_W-1:0]                we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [DATA_W-1:0]              wdata,
   output logic [DATA_W-1:0]              rdata
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   // Lanes being written this cycle are forwarded straight to the read port.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
         if (re) begin
            rdata[8*i +: 8] <= we[i] ? wdata[8*i +: 8] : mem[addr][8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/core_dtcm_avl.sv
// Tightly-coupled data memory as an Avalon-style burst slave: one-cycle read
// latency, full throughput, read response held under backpressure.
module core_dtcm_avl
   import core_define::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int BURST_W     = BURST_W_DEF
) (
   input  logic               clk,
   input  logic               rest,
   input  logic [31:0]        avl_s0_address,
   input  logic               avl_s0_read,
   input  logic               avl_s0_write,
   input  logic [BE_W-1:0]    avl_s0_byte_en,
   input  logic [DATA_W-1:0]  avl_s0_write_data,
   input  logic               avl_s0_begin_burst_transfer,
   input  logic [BURST_W-1:0] avl_s0_burst_count,
   output logic               avl_s0_request_ready,
   output logic [DATA_W-1:0]  avl_s0_read_data,
   output logic               avl_s0_read_data_valid,
   input  logic               avl_s0_resp_ready
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [1:0]         state;
   logic [BURST_W-1:0] remaining;
   logic [IDX_W-1:0]   nxt_idx;
   logic               rd_vld_p1;

   logic [IDX_W-1:0]   req_idx;
   logic [IDX_W-1:0]   ram_addr;
   logic [BE_W-1:0]    ram_we;
   logic               ram_re;
   logic [DATA_W-1:0]  ram_rdata;
   logic               slot_free, idle_rdy, acc_rd, acc_wr, rd_beat, wr_beat;
   logic               multi, last_beat;
   logic               unused_ok;

   // Upper address bits alias; the first beat is recognised by acceptance in IDLE.
   assign unused_ok = ^{avl_s0_address[31:IDX_W+2], avl_s0_address[1:0],
                        avl_s0_begin_burst_transfer};

   assign req_idx   = avl_s0_address[IDX_W+1:2];
   assign slot_free = !rd_vld_p1 || avl_s0_resp_ready;
   assign idle_rdy  = rest && (state == ST_IDLE) && slot_free;
   assign acc_wr    = idle_rdy && avl_s0_write;
   assign acc_rd    = idle_rdy && avl_s0_read && !avl_s0_write;
   assign rd_beat   = rest && (state == ST_RD_BURST) && slot_free;
   assign wr_beat   = rest && (state == ST_WR_BURST) && avl_s0_write;
   assign multi     = avl_s0_burst_count > BURST_W'(1);
   assign last_beat = remaining == BURST_W'(1);

   assign avl_s0_request_ready = idle_rdy || (rest && (state == ST_WR_BURST));

   assign ram_addr = (state == ST_IDLE) ? req_idx : nxt_idx;
   assign ram_re   = acc_rd || rd_beat;
   assign ram_we   = (acc_wr || wr_beat) ? avl_s0_byte_en : '0;

   core_dtcm_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .re    (ram_re),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (avl_s0_write_data),
      .rdata (ram_rdata)
   );

   // ---- p0 -> p1: RAM launch to registered response ----
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state     <= ST_IDLE;
         remaining <= '0;
         nxt_idx   <= '0;
         rd_vld_p1 <= 1'b0;
      end else begin
         if (slot_free) begin
            rd_vld_p1 <= ram_re;
         end
         case (state)
            ST_IDLE: begin
               if (acc_wr && multi) begin
                  state     <= ST_WR_BURST;
                  remaining <= avl_s0_burst_count - BURST_W'(1);
                  nxt_idx   <= req_idx + IDX_W'(1);
               end else if (acc_rd && multi) begin
                  state     <= ST_RD_BURST;
                  remaining <= avl_s0_burst_count - BURST_W'(1);
                  nxt_idx   <= req_idx + IDX_W'(1);
               end
            end
            ST_RD_BURST, ST_WR_BURST: begin
               if (rd_beat || wr_beat) begin
                  nxt_idx   <= nxt_idx + IDX_W'(1);
                  remaining <= remaining - BURST_W'(1);
                  if (last_beat) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The RAM output register has no reset, so the response is masked until valid.
   assign avl_s0_read_data       = rd_vld_p1 ? ram_rdata : '0;
   assign avl_s0_read_data_valid = rd_vld_p1;

endmodule
